sys_spi_master: RTL

//  Byte-stream SPI master speaking the Tangcores sys command link from the MCU side (cmd byte + payload,
//  MSB-first, CS framed). Drives sspi_cs/clk/mosi into a sys slave and captures sspi_miso bytes.

---
 rtl/sys_spi_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sys_spi_master.sv
// Byte-stream SPI master (mode 0, MSB first) for the sys command link.
// One byte per tx handshake; CS stays low across a frame until the byte flagged last completes.
module sys_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sspi_cs,
  output logic       sspi_clk,
  output logic       sspi_mosi,
  input  logic       sspi_miso
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_END = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE, S_WAIT, S_HOLD, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       bit_q;
  logic [7:0]       tx_q;
  logic [6:0]       rx_shift_q;
  logic [7:0]       rx_data_q;
  logic             last_q, cs_q, sclk_q, mosi_q, rdy_en_q;
  logic             accept, phase_end, gap_end;

  assign phase_end = (div_q == DIV_END);
  assign gap_end   = (div_q == GAP_END);
  assign accept    = tx_valid & tx_ready;

  assign rx_data   = rx_data_q;
  assign sspi_cs   = cs_q;
  assign sspi_clk  = sclk_q;
  assign sspi_mosi = mosi_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_SETUP;
      S_SETUP: if (phase_end) state_d = S_HIGH;
      S_HIGH:  if (phase_end) state_d = (bit_q == 3'd7) ? S_DONE : S_LOW;
      S_LOW:   if (phase_end) state_d = S_HIGH;
      S_DONE:                 state_d = last_q ? S_HOLD : S_WAIT;
      S_WAIT:  if (accept)    state_d = S_LOW;
      S_HOLD:  if (phase_end) state_d = S_GAP;
      S_GAP:   if (gap_end)   state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
    // Counter restarts on every state change; IDLE/WAIT ignore it.
    div_d = (state_d == state_q) ? div_q + CNT_W'(1) : '0;
  end

  always_comb begin
    tx_ready = rdy_en_q & ((state_q == S_IDLE) | (state_q == S_WAIT));
    rx_valid = (state_q == S_DONE);
    busy     = (state_q != S_IDLE);
  end

  // tx_q holds the bits still to be sent, next one in bit 7.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      bit_q      <= 3'd0;
      tx_q       <= 8'h00;
      last_q     <= 1'b0;
      rx_shift_q <= 7'h00;
      rx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (accept) begin
            cs_q   <= 1'b0;
            mosi_q <= tx_data[7];
            tx_q   <= {tx_data[6:0], 1'b0};
            last_q <= tx_last;
            bit_q  <= 3'd0;
          end
        end
        S_SETUP, S_LOW: if (phase_end) sclk_q <= 1'b1;
        S_HIGH: begin
          if (phase_end) begin
            sclk_q     <= 1'b0;
            rx_shift_q <= {rx_shift_q[5:0], sspi_miso};
            if (bit_q == 3'd7) begin
              rx_data_q <= {rx_shift_q, sspi_miso};
            end else begin
              mosi_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
              bit_q  <= bit_q + 3'd1;
            end
          end
        end
        S_HOLD: if (phase_end) cs_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
